// File: rtl/cpu_bus_sync_pkg.sv
// Shared definitions for the external CPU bus synchronizer.
//   ADDR_W  - register address width
//   DATA_W  - register data width
//   CNT_W   - width of the read-settle counter (holds READ_SETTLE up to 7)
//   state_t - bus-handshake FSM states
package cpu_bus_sync_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR_STROBE,
        WR_WAIT,
        RD_SETTLE,
        RD_HOLD,
        ERR_WAIT
    } state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for one asynchronous, active-low strobe.
//   clk   - destination clock
//   reset - asynchronous active-high reset; every stage resets to 1 (inactive)
//   d     - asynchronous input
//   q     - synchronized output, STAGES clk cycles behind d
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state is assigned with <= so every stage samples the
    // value its neighbour held before the edge; blocking = would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cpu_bus_sync.sv
// Bridges an asynchronous external CPU bus (active-low cs/rd/wr strobes) onto
// a synchronous internal register bank.
//   clk, reset                      - system clock, async active-high reset
//   ext_cs_n, ext_rd_n, ext_wr_n    - external strobes (async, active-low)
//   ext_addr, ext_data_in           - external address / write data
//   ext_data_out, ext_data_oe       - read data and pad output enable
//   cpu_rd, cpu_wr                  - internal read select (level) / write pulse
//   cpu_address, cpu_wdata          - internal address / write data (held)
//   cpu_rdata                       - internal read data, valid READ_SETTLE
//                                     cycles after cpu_rd rises
//   protocol_err                    - sticky flag for rd and wr low together
module cpu_bus_sync
    import cpu_bus_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int READ_SETTLE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_cs_n,
    input  logic              ext_rd_n,
    input  logic              ext_wr_n,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data_in,
    output logic [DATA_W-1:0] ext_data_out,
    output logic              ext_data_oe,
    output logic              cpu_rd,
    output logic              cpu_wr,
    output logic [ADDR_W-1:0] cpu_address,
    output logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] cpu_rdata,
    output logic              protocol_err
);

    logic cs_s, rd_s, wr_s;
    logic sel_rd, sel_wr;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .reset(reset), .d(ext_cs_n), .q(cs_s));
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (.clk(clk), .reset(reset), .d(ext_rd_n), .q(rd_s));
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (.clk(clk), .reset(reset), .d(ext_wr_n), .q(wr_s));

    assign sel_rd = ~cs_s & ~rd_s;
    assign sel_wr = ~cs_s & ~wr_s;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              rd_nxt, wr_nxt, oe_nxt, err_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt, dout_nxt;

    // Every output is registered. cpu_wr is the registered image of the
    // WR_STROBE state, so it rises on the edge that leaves WR_STROBE; this
    // puts the pulse SYNC_STAGES+2 cycles after the pin edge. Likewise the
    // settle counter is loaded with READ_SETTLE and the capture happens on the
    // cycle it is already 0, giving ext_data_oe at SYNC_STAGES+READ_SETTLE+2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cpu_rd       <= 1'b0;
            cpu_wr       <= 1'b0;
            ext_data_oe  <= 1'b0;
            protocol_err <= 1'b0;
            cpu_address  <= '0;
            cpu_wdata    <= '0;
            ext_data_out <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cpu_rd       <= rd_nxt;
            cpu_wr       <= wr_nxt;
            ext_data_oe  <= oe_nxt;
            protocol_err <= err_nxt;
            cpu_address  <= addr_nxt;
            cpu_wdata    <= wdata_nxt;
            ext_data_out <= dout_nxt;
        end
    end

    // NOTE: every signal written here is given a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_nxt    = cpu_rd;
        wr_nxt    = 1'b0;
        oe_nxt    = ext_data_oe;
        err_nxt   = protocol_err;
        addr_nxt  = cpu_address;
        wdata_nxt = cpu_wdata;
        dout_nxt  = ext_data_out;

        unique case (state)
            IDLE: begin
                if (sel_rd && sel_wr) begin
                    err_nxt   = 1'b1;
                    state_nxt = ERR_WAIT;
                end else if (sel_wr) begin
                    addr_nxt  = ext_addr;
                    wdata_nxt = ext_data_in;
                    state_nxt = WR_STROBE;
                end else if (sel_rd) begin
                    addr_nxt  = ext_addr;
                    rd_nxt    = 1'b1;
                    cnt_nxt   = CNT_W'(READ_SETTLE);
                    state_nxt = RD_SETTLE;
                end
            end
            WR_STROBE: begin
                wr_nxt    = 1'b1;
                state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                // Wait for the strobe to go away so one external write
                // can never produce a second pulse.
                if (!sel_wr) begin
                    state_nxt = IDLE;
                end
            end
            RD_SETTLE: begin
                // An abort takes priority over a capture on the same cycle.
                if (!sel_rd) begin
                    rd_nxt    = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    dout_nxt  = cpu_rdata;
                    oe_nxt    = 1'b1;
                    state_nxt = RD_HOLD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RD_HOLD: begin
                if (!sel_rd) begin
                    rd_nxt    = 1'b0;
                    oe_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            ERR_WAIT: begin
                if (!sel_rd && !sel_wr) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/cpu_bus_sync.md
CPU_BUS_SYNC -- requirements
Module: cpu_bus_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on external strobes; legal range 2..4.
REQ-002 Parameter READ_SETTLE, default 2: clk cycles between asserting cpu_rd and sampling cpu_rdata; legal range 1..7.
REQ-003 Port clk, input, 1: single system clock; all state is on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port ext_cs_n, input, 1: external CPU chip select, active-low, asynchronous to clk.
REQ-006 Port ext_rd_n, input, 1: external read strobe, active-low, asynchronous to clk.
REQ-007 Port ext_wr_n, input, 1: external write strobe, active-low, asynchronous to clk.
REQ-008 Port ext_addr, input, 6: external address, stable while any strobe is low.
REQ-009 Port ext_data_in, input, 16: external write data, stable while ext_wr_n is low.
REQ-010 Port ext_data_out, output, 16: read data returned to the external CPU.
REQ-011 Port ext_data_oe, output, 1: pad output enable for ext_data_out.
REQ-012 Port cpu_rd, output, 1: internal register-bank read select, level.
REQ-013 Port cpu_wr, output, 1: internal register-bank write strobe, one clk cycle wide.
REQ-014 Port cpu_address, output, 6: internal register address.
REQ-015 Port cpu_wdata, output, 16: internal write data.
REQ-016 Port cpu_rdata, input, 16: internal read data, valid READ_SETTLE cycles after cpu_rd rises.
REQ-017 Port protocol_err, output, 1: sticky flag set on an illegal strobe combination.

Function
REQ-018 Each of ext_cs_n, ext_rd_n and ext_wr_n shall pass through a SYNC_STAGES flop chain; sel_rd = ~cs_s & ~rd_s and sel_wr = ~cs_s & ~wr_s use the synchronized values only.
REQ-019 The FSM shall have the states IDLE, WR_STROBE, WR_WAIT, RD_SETTLE, RD_HOLD and ERR_WAIT.
REQ-020 IDLE: sel_wr alone shall register ext_addr into cpu_address and ext_data_in into cpu_wdata, then go to WR_STROBE.
REQ-021 IDLE: sel_rd alone shall register ext_addr into cpu_address, assert cpu_rd, load the settle counter with READ_SETTLE, then go to RD_SETTLE.
REQ-022 IDLE: sel_rd and sel_wr together shall set protocol_err and go to ERR_WAIT, with no cpu_rd and no cpu_wr.
REQ-023 WR_STROBE shall assert cpu_wr for exactly one cycle, then go to WR_WAIT.
REQ-024 WR_WAIT shall remain until sel_wr is low, then go to IDLE, so each external write produces exactly one cpu_wr pulse.
REQ-025 RD_SETTLE shall decrement the counter; on reaching 0 it shall capture cpu_rdata into ext_data_out, set ext_data_oe, and go to RD_HOLD.
REQ-026 RD_HOLD shall keep ext_data_oe high and ext_data_out stable until sel_rd is low; it shall then clear cpu_rd and ext_data_oe in the same cycle and go to IDLE.
REQ-027 If sel_rd drops during RD_SETTLE (read aborted), the FSM shall clear cpu_rd, leave ext_data_oe low, and go to IDLE.
REQ-028 ERR_WAIT shall remain until both sel_rd and sel_wr are low, then go to IDLE.
REQ-029 protocol_err shall clear only on reset.
REQ-030 Latency: a cs+wr low edge at the pins shall produce cpu_wr SYNC_STAGES+2 cycles later; ext_data_oe shall rise SYNC_STAGES+READ_SETTLE+2 cycles after the cs+rd low edge.
REQ-031 cpu_address and cpu_wdata shall hold their last values outside transactions.

Reset
REQ-032 When reset is asserted, the block shall clear all sync flops to 1 (strobes inactive) and force the FSM to IDLE.
REQ-033 During reset, cpu_rd, cpu_wr, ext_data_oe and protocol_err shall be 0, and cpu_address, cpu_wdata and ext_data_out shall be 0.
REQ-034 Reset mid-transaction shall abandon it with no cpu_wr pulse; if strobes are still low at reset release, the block shall enter the matching transaction after resynchronization.

Structure
REQ-035 A shared package shall hold the FSM state enum, the 6-bit address width and the 16-bit data width.
REQ-036 A single sub-module, bit_sync (parameterized depth, reset value 1), shall be instantiated three times.

Verification
REQ-037 Write: ext_addr=0x05, data=0xA5C3, wr low for 10 cycles -> exactly one cpu_wr pulse with cpu_address=0x05 and cpu_wdata=0xA5C3.
REQ-038 Read: cpu_rdata=0x1234 at address 0x05, rd low for 12 cycles -> ext_data_out=0x1234 with ext_data_oe high until 1 cycle after rd_s rises.
REQ-039 Back-to-back: write then read with a 1-cycle strobe gap -> one cpu_wr pulse, then a correct read, with no overlap between cpu_wr and cpu_rd.
REQ-040 Illegal: rd and wr low together -> protocol_err=1, no strobes issued; it stays 1 through a following legal write.
REQ-041 Abort: rd low for 1 synchronized cycle with READ_SETTLE=3 -> cpu_rd pulses, ext_data_oe is never asserted, and the FSM returns to IDLE.
REQ-042 Reset mid-WR_WAIT with wr held low -> outputs are 0; after reset release a new single cpu_wr pulse is issued.
